// File: rtl/eth_sw_pkg.sv
// Shared switch types: word width, buffer entry layout, receive FSM states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package eth_sw_pkg;

  localparam int ETH_WORD_W = 32;
  localparam logic [ETH_WORD_W-1:0] ETH_BCAST_ADDR = 32'hFFFF_FFFF;

  typedef logic [ETH_WORD_W-1:0] eth_word_t;

  typedef struct packed {
    logic      sop;
    logic      eop;
    eth_word_t data;
  } eth_buf_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    DISCARD = 2'd2
  } rx_state_e;

  // 16-bit counter add that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + 17'(inc);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/eth_port_rx_if.sv
// Port-side bundle: sop/eop framed ingress words plus egress valid/ready stream.
// Latency: n/a (wires only).
// Backpressure: portStall toward the sender, outReady from the fabric.
interface eth_port_rx_if;
  import eth_sw_pkg::*;

  eth_word_t inData;
  logic      sopI;
  logic      eopI;
  logic      portStall;
  eth_word_t outData;
  logic      outSop;
  logic      outEop;
  logic      outValid;
  logic      outReady;

  // Bench / upstream side: drives ingress and fabric ready.
  modport master (
    output inData, sopI, eopI, outReady,
    input  portStall, outData, outSop, outEop, outValid
  );

  // Receiver side.
  modport slave (
    input  inData, sopI, eopI, outReady,
    output portStall, outData, outSop, outEop, outValid
  );
endinterface

// File: rtl/eth_rx_buf.sv
// Store-and-forward word buffer with speculative write, commit and rollback pointers.
// Latency: a committed word is readable the cycle after its commit strobe.
// Backpressure: none internally; caller gates writes with full and reads with cmt_empty.
module eth_rx_buf
  import eth_sw_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             wr_en,
  input  eth_buf_entry_t   wr_entry,
  input  logic             commit,
  input  logic             rollback,
  input  logic             rd_en,
  output eth_buf_entry_t   rd_entry,
  output logic [PTR_W-1:0] used,
  output logic             full,
  output logic             cmt_empty
);

  localparam int AW = PTR_W - 1;

  eth_buf_entry_t   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] cmt_ptr_q, cmt_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_base;

  // Rollback rewinds the write pointer first, so a restarted packet lands at the commit point.
  always_comb begin
    wr_base   = rollback ? cmt_ptr_q : wr_ptr_q;
    wr_ptr_d  = wr_base + PTR_W'(wr_en);
    cmt_ptr_d = commit ? wr_ptr_d : cmt_ptr_q;
    rd_ptr_d  = rd_ptr_q + PTR_W'(rd_en);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr_q  <= '0;
      cmt_ptr_q <= '0;
      rd_ptr_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      cmt_ptr_q <= cmt_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_base[AW-1:0]] <= wr_entry;
  end

  assign rd_entry  = mem[rd_ptr_q[AW-1:0]];
  assign used      = wr_ptr_q - rd_ptr_q;
  assign full      = (used == PTR_W'(DEPTH));
  assign cmt_empty = (cmt_ptr_q == rd_ptr_q);

endmodule

// File: rtl/eth_port_rx.sv
// Switch port ingress: buffers framed packets, releases only complete good ones. Optional macro ETH_RX_ADDR_FILTER_EN drops packets whose word 0 is neither PORT_ADDR nor broadcast.
// Latency: first egress word valid 2 cycles after the eop write cycle; then 1 word/cycle.
// Backpressure: egress holds while outReady is low; portStall asks the sender to hold new packets.
module eth_port_rx
  import eth_sw_pkg::*;
#(
  parameter int        DEPTH         = 16,
  parameter int        MAX_PKT_WORDS = 16,
  parameter eth_word_t PORT_ADDR     = 32'h0000_000A
) (
  input  logic               clk,
  input  logic               rstN,
  eth_port_rx_if.slave       port,
  output logic [15:0]        rxPktCnt,
  output logic [15:0]        dropCnt
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
`ifdef ETH_RX_ADDR_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  rx_state_e        state_q, state_d;
  logic [PTR_W-1:0] len_q, len_d;
  logic             addr_bad_q, addr_bad_d;
  logic             stall_q, stall_d;
  logic [15:0]      rx_cnt_q, rx_cnt_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic             out_vld_q, out_vld_d;
  eth_buf_entry_t   out_q, out_d;

  logic             wr_en, commit, rollback, rd_en, start_pkt, rx_inc;
  logic [1:0]       drop_inc;
  eth_buf_entry_t   wr_entry, rd_entry;
  logic [PTR_W-1:0] used;
  logic             buf_full, cmt_empty;

  eth_rx_buf #(.DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .rstN      (rstN),
    .wr_en     (wr_en),
    .wr_entry  (wr_entry),
    .commit    (commit),
    .rollback  (rollback),
    .rd_en     (rd_en),
    .rd_entry  (rd_entry),
    .used      (used),
    .full      (buf_full),
    .cmt_empty (cmt_empty)
  );

  // Receive FSM: a sop inside a packet aborts it and restarts on the same word.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    addr_bad_d = addr_bad_q;
    wr_en      = 1'b0;
    commit     = 1'b0;
    rollback   = 1'b0;
    rx_inc     = 1'b0;
    drop_inc   = 2'd0;
    start_pkt  = 1'b0;
    wr_entry   = '{sop: port.sopI, eop: port.eopI, data: port.inData};

    unique case (state_q)
      IDLE: begin
        if (port.sopI) start_pkt = 1'b1;
      end
      DISCARD: begin
        if (port.sopI)      start_pkt = 1'b1;
        else if (port.eopI) state_d   = IDLE;
      end
      RECV: begin
        if (port.sopI) begin
          rollback  = 1'b1;
          drop_inc  = 2'd1;
          start_pkt = 1'b1;
        end else if (buf_full || len_q == PTR_W'(MAX_PKT_WORDS)) begin
          rollback = 1'b1;
          drop_inc = 2'd1;
          // The eop of this packet may be the offending word itself.
          if (port.eopI) state_d = IDLE;
          else           state_d = DISCARD;
        end else begin
          wr_en = 1'b1;
          len_d = len_q + PTR_W'(1);
          if (port.eopI) begin
            state_d = IDLE;
            if (FILTER_EN && addr_bad_q) begin
              wr_en    = 1'b0;
              rollback = 1'b1;
              drop_inc = 2'd1;
            end else begin
              commit = 1'b1;
              rx_inc = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // New packet start; a runt (sop+eop) already carries its own end, so no discard wait.
    if (start_pkt) begin
      if (stall_q || port.eopI) begin
        drop_inc = drop_inc + 2'd1;
        if (port.eopI) state_d = IDLE;
        else           state_d = DISCARD;
      end else begin
        wr_en      = 1'b1;
        len_d      = PTR_W'(1);
        addr_bad_d = (port.inData != PORT_ADDR) && (port.inData != ETH_BCAST_ADDR);
        state_d    = RECV;
      end
    end
  end

  // Egress register stage, counters and stall threshold.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_d      = out_q;
    rd_en      = !cmt_empty && (!out_vld_q || port.outReady);
    if (rd_en) begin
      out_vld_d = 1'b1;
      out_d     = rd_entry;
    end else if (port.outReady) begin
      out_vld_d = 1'b0;
      out_d     = '0;
    end
    stall_d    = (PTR_W'(DEPTH) - used) < PTR_W'(MAX_PKT_WORDS);
    rx_cnt_d   = sat_add16(rx_cnt_q, {1'b0, rx_inc});
    drop_cnt_d = sat_add16(drop_cnt_q, drop_inc);
  end

  // State registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= IDLE;
      len_q      <= '0;
      addr_bad_q <= 1'b0;
      stall_q    <= 1'b0;
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
      out_vld_q  <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      addr_bad_q <= addr_bad_d;
      stall_q    <= stall_d;
      rx_cnt_q   <= rx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      out_vld_q  <= out_vld_d;
      out_q      <= out_d;
    end
  end

  assign port.portStall = stall_q;
  assign port.outValid  = out_vld_q;
  assign port.outSop    = out_q.sop;
  assign port.outEop    = out_q.eop;
  assign port.outData   = out_q.data;
  assign rxPktCnt       = rx_cnt_q;
  assign dropCnt        = drop_cnt_q;

endmodule

// File: tb/tb_eth_port_rx.sv
// Directed bench for eth_port_rx: cycle table for the basic flows, hand sequences for corners.
// Latency: n/a.
// Backpressure: outReady driven per sequence.
module tb_eth_port_rx;
  import eth_sw_pkg::*;

  logic        clk = 1'b0;
  logic        rstN;
  logic [15:0] rxPktCnt, dropCnt;
  logic        rdy_want;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [33:0] cap_q[$];
  logic [33:0] exp_q[$];

  eth_port_rx_if bus ();

  eth_port_rx #(.DEPTH(16), .MAX_PKT_WORDS(8), .PORT_ADDR(32'h0000_000A)) dut (
    .clk      (clk),
    .rstN     (rstN),
    .port     (bus),
    .rxPktCnt (rxPktCnt),
    .dropCnt  (dropCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sop, eop;
    logic [31:0] dat;
    logic        vld, osop, oeop;
    logic [31:0] odat;
    logic [15:0] rx, drop;
  } vec_t;

  vec_t tv[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic row(input int i, input logic s, input logic e, input logic [31:0] d,
                     input logic ov, input logic os, input logic oe, input logic [31:0] od,
                     input logic [15:0] r, input logic [15:0] dr);
    tv[i] = '{sop: s, eop: e, dat: d, vld: ov, osop: os, oeop: oe, odat: od, rx: r, drop: dr};
  endtask

  // One cycle: apply ready at the negedge, then record a transfer that the next posedge completes.
  task automatic tick();
    @(negedge clk);
    bus.outReady = rdy_want;
    if (bus.outValid && bus.outReady) cap_q.push_back({bus.outSop, bus.outEop, bus.outData});
  endtask

  task automatic drive(input logic s, input logic e, input logic [31:0] d);
    tick();
    bus.sopI   = s;
    bus.eopI   = e;
    bus.inData = d;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 32'h0);
  endtask

  task automatic send(input logic [31:0] w0, input logic [31:0] base, input int n);
    drive(1'b1, n == 1, w0);
    for (int k = 1; k < n; k++) drive(1'b0, k == n - 1, base + k);
  endtask

  task automatic expect_pkt(input logic [31:0] w0, input logic [31:0] base, input int n);
    exp_q.push_back({1'b1, n == 1, w0});
    for (int k = 1; k < n; k++) exp_q.push_back({1'b0, k == n - 1, base + k});
  endtask

  task automatic check_q(input string name);
    check({name, "_count"}, cap_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++)
      check($sformatf("%s_w%0d", name, k), {30'h0, cap_q[k][33:32]} ^ cap_q[k][31:0] ^ 32'(k << 8),
            {30'h0, exp_q[k][33:32]} ^ exp_q[k][31:0] ^ 32'(k << 8));
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rstN       = 1'b0;
    bus.sopI   = 1'b0;
    bus.eopI   = 1'b0;
    bus.inData = '0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    cap_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rstN         = 1'b0;
    rdy_want     = 1'b1;
    bus.outReady = 1'b1;
    bus.sopI     = 1'b0;
    bus.eopI     = 1'b0;
    bus.inData   = '0;

    // Cycle table, outReady high throughout: 4-word packet, runt + 3-word, sop mid-packet.
    for (int i = 0; i < 32; i++) row(i, 0, 0, 0, 0, 0, 0, 0, 3, 2);
    row(0, 1, 0, 32'h0000_000A, 0, 0, 0, 0, 0, 0);
    row(1, 0, 0, 32'h11, 0, 0, 0, 0, 0, 0);
    row(2, 0, 0, 32'h22, 0, 0, 0, 0, 0, 0);
    row(3, 0, 1, 32'h33, 0, 0, 0, 0, 0, 0);
    row(4, 0, 0, 0,      0, 0, 0, 0, 1, 0);
    row(5, 0, 0, 0,      1, 1, 0, 32'h0000_000A, 1, 0);
    row(6, 0, 0, 0,      1, 0, 0, 32'h11, 1, 0);
    row(7, 0, 0, 0,      1, 0, 0, 32'h22, 1, 0);
    row(8, 0, 0, 0,      1, 0, 1, 32'h33, 1, 0);
    row(9, 0, 0, 0,      0, 0, 0, 0, 1, 0);
    row(10, 1, 1, 32'hDEAD, 0, 0, 0, 0, 1, 0);
    row(11, 0, 0, 0,     0, 0, 0, 0, 1, 1);
    row(12, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 1);
    row(13, 0, 0, 32'h101, 0, 0, 0, 0, 1, 1);
    row(14, 0, 1, 32'h102, 0, 0, 0, 0, 1, 1);
    row(15, 0, 0, 0,     0, 0, 0, 0, 2, 1);
    row(16, 0, 0, 0,     1, 1, 0, 32'hFFFF_FFFF, 2, 1);
    row(17, 0, 0, 0,     1, 0, 0, 32'h101, 2, 1);
    row(18, 0, 0, 0,     1, 0, 1, 32'h102, 2, 1);
    row(19, 0, 0, 0,     0, 0, 0, 0, 2, 1);
    row(20, 1, 0, 32'h200, 0, 0, 0, 0, 2, 1);
    row(21, 0, 0, 32'h201, 0, 0, 0, 0, 2, 1);
    row(22, 1, 0, 32'h0000_000A, 0, 0, 0, 0, 2, 1);
    row(23, 0, 0, 32'h301, 0, 0, 0, 0, 2, 2);
    row(24, 0, 0, 32'h302, 0, 0, 0, 0, 2, 2);
    row(25, 0, 1, 32'h303, 0, 0, 0, 0, 2, 2);
    row(27, 0, 0, 0,     1, 1, 0, 32'h0000_000A, 3, 2);
    row(28, 0, 0, 0,     1, 0, 0, 32'h301, 3, 2);
    row(29, 0, 0, 0,     1, 0, 0, 32'h302, 3, 2);
    row(30, 0, 0, 0,     1, 0, 1, 32'h303, 3, 2);

    // Reset state, sampled after a clock edge with reset held low.
    @(negedge clk);
    check("rst_vld", bus.outValid, 0);
    check("rst_sop", bus.outSop, 0);
    check("rst_eop", bus.outEop, 0);
    check("rst_data", bus.outData, 0);
    check("rst_stall", bus.portStall, 0);
    check("rst_rx", rxPktCnt, 0);
    check("rst_drop", dropCnt, 0);
    @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check($sformatf("c%0d_vld", i), bus.outValid, tv[i].vld);
      check($sformatf("c%0d_sop", i), bus.outSop, tv[i].osop);
      check($sformatf("c%0d_eop", i), bus.outEop, tv[i].oeop);
      check($sformatf("c%0d_data", i), bus.outData, tv[i].odat);
      check($sformatf("c%0d_rx", i), rxPktCnt, tv[i].rx);
      check($sformatf("c%0d_drop", i), dropCnt, tv[i].drop);
      check($sformatf("c%0d_stall", i), bus.portStall, 0);
      bus.sopI   = tv[i].sop;
      bus.eopI   = tv[i].eop;
      bus.inData = tv[i].dat;
    end

    // Two max-length packets with the fabric stalled, then a third that must be refused.
    do_reset();
    rdy_want = 1'b0;
    send(32'hFFFF_FFFF, 32'h400, 8);
    send(32'hFFFF_FFFF, 32'h500, 8);
    idle(2);
    check("stall_high", bus.portStall, 1);
    check("stall_hold_vld", bus.outValid, 1);
    check("stall_hold_data", bus.outData, 32'hFFFF_FFFF);
    send(32'hFFFF_FFFF, 32'h600, 3);
    idle(2);
    check("stall_drop", dropCnt, 1);
    check("stall_rx", rxPktCnt, 2);
    rdy_want = 1'b1;
    idle(24);
    expect_pkt(32'hFFFF_FFFF, 32'h400, 8);
    expect_pkt(32'hFFFF_FFFF, 32'h500, 8);
    check_q("drain");
    check("stall_low", bus.portStall, 0);

    // Reset pulse in the middle of a packet.
    do_reset();
    rdy_want = 1'b0;
    send(32'h0000_000A, 32'h700, 2);
    idle(3);
    check("prerst_vld", bus.outValid, 1);
    check("prerst_rx", rxPktCnt, 1);
    drive(1'b1, 1'b0, 32'h0000_000A);
    drive(1'b0, 1'b0, 32'h801);
    drive(1'b0, 1'b0, 32'h802);
    #2 rstN = 1'b0;
    #1;
    check("midrst_vld", bus.outValid, 0);
    check("midrst_sop", bus.outSop, 0);
    check("midrst_eop", bus.outEop, 0);
    check("midrst_data", bus.outData, 0);
    check("midrst_stall", bus.portStall, 0);
    check("midrst_rx", rxPktCnt, 0);
    check("midrst_drop", dropCnt, 0);
    @(negedge clk);
    rstN = 1'b1;
    drive(1'b0, 1'b0, 32'h803);
    drive(1'b0, 1'b1, 32'h804);
    rdy_want = 1'b1;
    idle(6);
    send(32'h0000_000A, 32'h900, 3);
    idle(8);
    expect_pkt(32'h0000_000A, 32'h900, 3);
    check_q("postrst");
    check("postrst_rx", rxPktCnt, 1);
    check("postrst_drop", dropCnt, 0);

    // Address filter: foreign, broadcast and own address.
    do_reset();
    rdy_want = 1'b1;
    send(32'h0000_000B, 32'hA00, 3);
    send(32'hFFFF_FFFF, 32'hB00, 2);
    send(32'h0000_000A, 32'hC00, 2);
    idle(8);
`ifdef ETH_RX_ADDR_FILTER_EN
    expect_pkt(32'hFFFF_FFFF, 32'hB00, 2);
    expect_pkt(32'h0000_000A, 32'hC00, 2);
    check_q("filter");
    check("filter_rx", rxPktCnt, 2);
    check("filter_drop", dropCnt, 1);
`else
    expect_pkt(32'h0000_000B, 32'hA00, 3);
    expect_pkt(32'hFFFF_FFFF, 32'hB00, 2);
    expect_pkt(32'h0000_000A, 32'hC00, 2);
    check_q("nofilter");
    check("nofilter_rx", rxPktCnt, 3);
    check("nofilter_drop", dropCnt, 0);
`endif

    // Length limit: one word over is dropped, exactly the limit passes.
    do_reset();
    send(32'h0000_000A, 32'hD00, 9);
    idle(6);
    check_q("toolong");
    check("toolong_drop", dropCnt, 1);
    check("toolong_rx", rxPktCnt, 0);
    send(32'h0000_000A, 32'hE00, 8);
    idle(14);
    expect_pkt(32'h0000_000A, 32'hE00, 8);
    check_q("maxlen");
    check("maxlen_rx", rxPktCnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
